// File: rtl/riscv_wb_pkg.sv
// Shared constants and types for the writeback stage: write-select and load
// funct3 encodings, the writeback state enum and the datapath width.
package riscv_wb_pkg;

    localparam int XLEN       = 32;
    localparam int ADDR_LOW_W = 2;

    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_LOAD = 2'b10;
    localparam logic [1:0] WB_PC4  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_WB        = 2'd1,
        ST_LOAD_WAIT = 2'd2
    } wb_state_e;

endpackage

// File: rtl/regfile_writeback_load_extend.sv
// Load data alignment: picks the byte or half addressed by addr_low out of the
// raw memory word and sign- or zero-extends it according to funct3.
module load_extend
    import riscv_wb_pkg::*;
(
    input  logic [2:0]            funct3,
    input  logic [ADDR_LOW_W-1:0] addr_low,
    input  logic [XLEN-1:0]       word,
    output logic [XLEN-1:0]       result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[7:0];
        case (addr_low)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
    end

    assign half_v = addr_low[1] ? word[31:16] : word[15:0];

    // LW and every unlisted code pass the full word through.
    always_comb begin
        result = word;
        case (funct3)
            F3_LB:   result = {{24{byte_v[7]}}, byte_v};
            F3_LH:   result = {{16{half_v[15]}}, half_v};
            F3_LBU:  result = {24'd0, byte_v};
            F3_LHU:  result = {16'd0, half_v};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: drives the register file write port, waits for load data and
// keeps a pending-write scoreboard for decode. Optional REGFILE_WB_BYPASS_EN adds
// a forwarding path from the WB cycle that suppresses the matching hazard.
module regfile_writeback
    import riscv_wb_pkg::*;
#(
    parameter int MEM_DEPTH_W = ADDR_LOW_W
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [4:0]             ex_rd,
    input  logic [1:0]             ex_wb_sel,
    input  logic [XLEN-1:0]        ex_alu_result,
    input  logic [XLEN-1:0]        ex_pc,
    input  logic [2:0]             ex_load_funct3,
    input  logic [MEM_DEPTH_W-1:0] ex_addr_low,
    input  logic                   mem_rsp_valid,
    input  logic [XLEN-1:0]        mem_rsp_data,
    input  logic [4:0]             addr_rs1,
    input  logic [4:0]             addr_rs2,
    output logic                   hazard_rs1,
    output logic                   hazard_rs2,
    output logic [4:0]             addr_rd,
    output logic [XLEN-1:0]        data_rd,
    output logic                   write_enable,
`ifdef REGFILE_WB_BYPASS_EN
    output logic                   bypass_rs1_valid,
    output logic                   bypass_rs2_valid,
    output logic [XLEN-1:0]        bypass_data,
`endif
    output logic [31:0]            busy,
    output logic [1:0]             state_dbg
);

    // Handshake: an execute result transfers on a clock edge where ex_valid and
    // ex_ready are both high; the producer holds its payload until then.

    wb_state_e              state_q, state_d;
    logic [4:0]             addr_rd_q, addr_rd_d;
    logic [XLEN-1:0]        data_rd_q, data_rd_d;
    logic                   we_q, we_d;
    logic [4:0]             ld_rd_q, ld_rd_d;
    logic [2:0]             ld_funct3_q, ld_funct3_d;
    logic [MEM_DEPTH_W-1:0] ld_addr_low_q, ld_addr_low_d;
    logic [31:0]            busy_q, busy_d;
    logic [XLEN-1:0]        load_data;
    logic                   accept;
    logic                   takes_write;

    load_extend u_load_extend (
        .funct3   (ld_funct3_q),
        .addr_low (ld_addr_low_q),
        .word     (mem_rsp_data),
        .result   (load_data)
    );

    assign ex_ready    = (state_q != ST_LOAD_WAIT);
    assign accept      = ex_valid && ex_ready;
    assign takes_write = accept && (ex_wb_sel != WB_NONE) && (ex_rd != 5'd0);

    always_comb begin
        state_d       = state_q;
        addr_rd_d     = addr_rd_q;
        data_rd_d     = data_rd_q;
        we_d          = 1'b0;
        ld_rd_d       = ld_rd_q;
        ld_funct3_d   = ld_funct3_q;
        ld_addr_low_d = ld_addr_low_q;
        busy_d        = busy_q;

        // Clear first so a same-edge set of the same register wins.
        if (state_q == ST_WB) begin
            busy_d[addr_rd_q] = 1'b0;
        end

        case (state_q)
            ST_EMPTY, ST_WB: begin
                state_d = ST_EMPTY;
                if (takes_write) begin
                    if (ex_wb_sel == WB_LOAD) begin
                        state_d       = ST_LOAD_WAIT;
                        ld_rd_d       = ex_rd;
                        ld_funct3_d   = ex_load_funct3;
                        ld_addr_low_d = ex_addr_low;
                    end else begin
                        state_d   = ST_WB;
                        we_d      = 1'b1;
                        addr_rd_d = ex_rd;
                        data_rd_d = (ex_wb_sel == WB_ALU) ? ex_alu_result
                                                          : ex_pc + 32'd4;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d   = ST_WB;
                    we_d      = 1'b1;
                    addr_rd_d = ld_rd_q;
                    data_rd_d = load_data;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (takes_write) begin
            busy_d[ex_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_EMPTY;
            addr_rd_q     <= 5'd0;
            data_rd_q     <= '0;
            we_q          <= 1'b0;
            ld_rd_q       <= 5'd0;
            ld_funct3_q   <= 3'd0;
            ld_addr_low_q <= '0;
            busy_q        <= 32'd0;
        end else begin
            state_q       <= state_d;
            addr_rd_q     <= addr_rd_d;
            data_rd_q     <= data_rd_d;
            we_q          <= we_d;
            ld_rd_q       <= ld_rd_d;
            ld_funct3_q   <= ld_funct3_d;
            ld_addr_low_q <= ld_addr_low_d;
            busy_q        <= busy_d;
        end
    end

    assign addr_rd      = addr_rd_q;
    assign data_rd      = data_rd_q;
    assign write_enable = we_q && !reset && (addr_rd_q != 5'd0);
    assign busy         = busy_q;
    assign state_dbg    = state_q;

`ifdef REGFILE_WB_BYPASS_EN
    assign bypass_rs1_valid = we_q && (addr_rs1 == addr_rd_q) && (addr_rs1 != 5'd0);
    assign bypass_rs2_valid = we_q && (addr_rs2 == addr_rd_q) && (addr_rs2 != 5'd0);
    assign bypass_data      = data_rd_q;
    assign hazard_rs1       = busy_q[addr_rs1] && (addr_rs1 != 5'd0) && !bypass_rs1_valid;
    assign hazard_rs2       = busy_q[addr_rs2] && (addr_rs2 != 5'd0) && !bypass_rs2_valid;
`else
    assign hazard_rs1       = busy_q[addr_rs1] && (addr_rs1 != 5'd0);
    assign hazard_rs2       = busy_q[addr_rs2] && (addr_rs2 != 5'd0);
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a transaction-level
// reference model (expected write queue plus per-register pending counts).
module tb_regfile_writeback;
    import riscv_wb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_wb_sel;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_pc;
    logic [2:0]  ex_load_funct3;
    logic [1:0]  ex_addr_low;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [4:0]  addr_rs1, addr_rs2;
    logic        hazard_rs1, hazard_rs2;
    logic [4:0]  addr_rd;
    logic [31:0] data_rd;
    logic        write_enable;
    logic [31:0] busy;
    logic [1:0]  state_dbg;
`ifdef REGFILE_WB_BYPASS_EN
    logic        bypass_rs1_valid, bypass_rs2_valid;
    logic [31:0] bypass_data;
`endif

    // clock / reset
    always #5 clock = ~clock;

    regfile_writeback dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_wb_sel(ex_wb_sel),
        .ex_alu_result(ex_alu_result), .ex_pc(ex_pc), .ex_load_funct3(ex_load_funct3),
        .ex_addr_low(ex_addr_low), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
        .addr_rd(addr_rd), .data_rd(data_rd), .write_enable(write_enable),
`ifdef REGFILE_WB_BYPASS_EN
        .bypass_rs1_valid(bypass_rs1_valid), .bypass_rs2_valid(bypass_rs2_valid),
        .bypass_data(bypass_data),
`endif
        .busy(busy), .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // reference model
    logic [36:0] exp_q[$];
    int          busy_cnt[32];
    bit          load_wait;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_al;
    bit          cur_we;
    logic [4:0]  cur_addr;
    logic [31:0] cur_data;
    bit          hold_txn;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] al,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (int'(al) * 8)) & 32'h0000_00FF;
        h = (w >> (al[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] v;
        v = 32'd0;
        for (int r = 1; r < 32; r++) v[r] = (busy_cnt[r] > 0);
        return v;
    endfunction

    function automatic logic exp_hazard(input logic [4:0] rs);
        logic hz;
        hz = (rs != 5'd0) && (busy_cnt[rs] > 0);
`ifdef REGFILE_WB_BYPASS_EN
        if (cur_we && rs == cur_addr && rs != 5'd0) hz = 1'b0;
`endif
        return hz;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        for (int r = 0; r < 32; r++) busy_cnt[r] = 0;
        load_wait = 0;
        cur_we    = 0;
        hold_txn  = 0;
    endtask

    // Applies the effect of the coming clock edge given the currently driven inputs.
    task automatic model_edge();
        bit acc;
        acc = ex_valid && !load_wait;
        hold_txn = ex_valid && !acc;
        if (cur_we) busy_cnt[cur_addr]--;
        if (load_wait) begin
            if (mem_rsp_valid) begin
                exp_q.push_back({ld_rd, ref_load(ld_f3, ld_al, mem_rsp_data)});
                load_wait = 0;
            end
        end else if (acc && ex_wb_sel != WB_NONE && ex_rd != 5'd0) begin
            busy_cnt[ex_rd]++;
            if (ex_wb_sel == WB_LOAD) begin
                load_wait = 1;
                ld_rd = ex_rd;
                ld_f3 = ex_load_funct3;
                ld_al = ex_addr_low;
            end else begin
                exp_q.push_back({ex_rd, (ex_wb_sel == WB_ALU) ? ex_alu_result : ex_pc + 32'd4});
            end
        end
    endtask

    // scoreboard: sampled at negedge
    task automatic check_all();
        logic [36:0] ent;
        cur_we = (exp_q.size() > 0);
        if (cur_we) begin
            ent      = exp_q.pop_front();
            cur_addr = ent[36:32];
            cur_data = ent[31:0];
        end
        check("ex_ready", {31'd0, ex_ready}, {31'd0, !load_wait});
        check("write_enable", {31'd0, write_enable}, {31'd0, cur_we});
        if (cur_we) begin
            check("addr_rd", {27'd0, addr_rd}, {27'd0, cur_addr});
            check("data_rd", data_rd, cur_data);
        end
        check("busy", busy, exp_busy());
        check("hazard_rs1", {31'd0, hazard_rs1}, {31'd0, exp_hazard(addr_rs1)});
        check("hazard_rs2", {31'd0, hazard_rs2}, {31'd0, exp_hazard(addr_rs2)});
`ifdef REGFILE_WB_BYPASS_EN
        check("bypass_rs1_valid", {31'd0, bypass_rs1_valid},
              {31'd0, cur_we && addr_rs1 == cur_addr && addr_rs1 != 5'd0});
        check("bypass_rs2_valid", {31'd0, bypass_rs2_valid},
              {31'd0, cur_we && addr_rs2 == cur_addr && addr_rs2 != 5'd0});
        if (cur_we) check("bypass_data", bypass_data, cur_data);
`endif
    endtask

    // driver
    task automatic step(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3,
                        input logic [1:0] al, input logic rv, input logic [31:0] rdata,
                        input logic [4:0] rs1, input logic [4:0] rs2);
        ex_valid = v; ex_rd = rd; ex_wb_sel = sel; ex_alu_result = alu; ex_pc = pc;
        ex_load_funct3 = f3; ex_addr_low = al; mem_rsp_valid = rv; mem_rsp_data = rdata;
        addr_rs1 = rs1; addr_rs2 = rs2;
        model_edge();
        @(posedge clock);
        @(negedge clock);
        check_all();
    endtask

    task automatic idle(input logic rv, input logic [31:0] rdata);
        step(1'b0, 5'd0, WB_NONE, 32'd0, 32'd0, 3'd0, 2'd0, rv, rdata, 5'd0, 5'd0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        model_clear();
        #1 check("reset_gates_we", {31'd0, write_enable}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        logic        r_v;
        logic [4:0]  r_rd;
        logic [1:0]  r_sel;
        logic [31:0] r_alu, r_pc;
        logic [2:0]  r_f3;
        logic [1:0]  r_al;

        reset = 1'b1;
        ex_valid = 0; ex_rd = 0; ex_wb_sel = 0; ex_alu_result = 0; ex_pc = 0;
        ex_load_funct3 = 0; ex_addr_low = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
        addr_rs1 = 0; addr_rs2 = 0;
        model_clear();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_addr_rd", {27'd0, addr_rd}, 32'd0);
        check("reset_data_rd", data_rd, 32'd0);
        check_all();

        // ALU write to x5
        step(1'b1, 5'd5, WB_ALU, 32'hDEADBEEF, 32'h100, 3'd0, 2'd0, 1'b0, 32'd0, 5'd5, 5'd0);
        check("alu5_addr", {27'd0, addr_rd}, 32'd5);
        check("alu5_data", data_rd, 32'hDEADBEEF);
        check("alu5_busy_set", {31'd0, busy[5]}, 32'd1);
        idle(1'b0, 32'd0);
        check("alu5_busy_clr", {31'd0, busy[5]}, 32'd0);

        // LB from lane 3, response three cycles later
        step(1'b1, 5'd9, WB_LOAD, 32'd0, 32'd0, 3'b000, 2'd3, 1'b0, 32'd0, 5'd9, 5'd0);
        check("lb_not_ready", {31'd0, ex_ready}, 32'd0);
        idle(1'b0, 32'd0);
        idle(1'b0, 32'd0);
        idle(1'b1, 32'h80FF_FF00);
        check("lb_data", data_rd, 32'hFFFF_FF80);
        idle(1'b0, 32'd0);

        // LBU, same lane and word
        step(1'b1, 5'd9, WB_LOAD, 32'd0, 32'd0, 3'b100, 2'd3, 1'b0, 32'd0, 5'd0, 5'd9);
        idle(1'b0, 32'd0);
        idle(1'b0, 32'd0);
        idle(1'b1, 32'h80FF_FF00);
        check("lbu_data", data_rd, 32'h0000_0080);

        // LH upper half, LHU lower half
        step(1'b1, 5'd4, WB_LOAD, 32'd0, 32'd0, 3'b001, 2'd2, 1'b1, 32'h0000_0000, 5'd0, 5'd0);
        idle(1'b1, 32'h9ABC_1234);
        check("lh_data", data_rd, 32'hFFFF_9ABC);
        step(1'b1, 5'd4, WB_LOAD, 32'd0, 32'd0, 3'b101, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0);
        idle(1'b1, 32'h1234_F00D);
        check("lhu_data", data_rd, 32'h0000_F00D);

        // back-to-back writes to x7: set wins over clear
        step(1'b1, 5'd7, WB_ALU, 32'h1111_1111, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0, 5'd7, 5'd0);
        step(1'b1, 5'd7, WB_ALU, 32'h2222_2222, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0, 5'd7, 5'd0);
        check("b2b_busy_overlap", {31'd0, busy[7]}, 32'd1);
        idle(1'b0, 32'd0);
        check("b2b_second_data", data_rd, 32'h2222_2222);
        idle(1'b0, 32'd0);
        check("b2b_busy_clr", {31'd0, busy[7]}, 32'd0);

        // rd = 0 is consumed silently
        step(1'b1, 5'd0, WB_ALU, 32'h0000_1234, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0);
        check("rd0_no_we", {31'd0, write_enable}, 32'd0);
        check("rd0_busy", busy, 32'd0);

        // PC4 wraps modulo 2^32
        step(1'b1, 5'd10, WB_PC4, 32'd0, 32'hFFFF_FFFC, 3'd0, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0);
        check("pc4_wrap", data_rd, 32'd0);
        idle(1'b0, 32'd0);

        // write to x3 while decode reads x3 in the WB cycle
        step(1'b1, 5'd3, WB_ALU, 32'h0000_0055, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0, 5'd0, 5'd3);
`ifdef REGFILE_WB_BYPASS_EN
        check("byp_rs2_valid", {31'd0, bypass_rs2_valid}, 32'd1);
        check("byp_data", bypass_data, 32'h0000_0055);
        check("byp_hazard_rs2", {31'd0, hazard_rs2}, 32'd0);
`else
        check("wb_hazard_rs2", {31'd0, hazard_rs2}, 32'd1);
`endif
        idle(1'b0, 32'd0);

        // reset while waiting for load data; late response must be ignored
        step(1'b1, 5'd12, WB_LOAD, 32'd0, 32'd0, 3'b010, 2'd0, 1'b0, 32'd0, 5'd12, 5'd0);
        idle(1'b0, 32'd0);
        pulse_reset();
        idle(1'b1, 32'hCAFE_F00D);
        check("rst_load_no_we", {31'd0, write_enable}, 32'd0);
        check("rst_load_busy", busy, 32'd0);

        // randomized traffic; held payload while not accepted
        r_v = 0; r_rd = 0; r_sel = 0; r_alu = 0; r_pc = 0; r_f3 = 0; r_al = 0;
        for (int i = 0; i < 800; i++) begin
            if (!hold_txn) begin
                r_v   = ($urandom_range(0, 3) != 0);
                r_rd  = 5'($urandom_range(0, 7));
                r_sel = 2'($urandom_range(0, 3));
                r_alu = $urandom;
                r_pc  = $urandom;
                r_f3  = 3'($urandom_range(0, 7));
                r_al  = 2'($urandom_range(0, 3));
            end
            step(r_v, r_rd, r_sel, r_alu, r_pc, r_f3, r_al,
                 ($urandom_range(0, 2) == 0), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
